// File: rtl/img_feeder_tcb_121_pkg.sv
// Shared definitions for the image feeder: frame geometry, FSM encoding and
// the result code reported when the NN top never answers.
package img_feeder_tcb_121_pkg;

  localparam int N_PIX = 121;
  localparam int PIX_W = 8;

  localparam logic [3:0] RES_ABORT = 4'hF;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_FIRE   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

endpackage

// File: rtl/img_feeder_tcb_121.sv
// Assembles a streamed frame into a flat vector, kicks the NN top with a
// one-cycle pulse, then captures its prediction (or a timeout abort code).
module img_feeder_tcb_121
  import img_feeder_tcb_121_pkg::*;
#(
  parameter int N_PIX       = img_feeder_tcb_121_pkg::N_PIX,
  parameter int PIX_W       = img_feeder_tcb_121_pkg::PIX_W,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PIX_W-1:0]       pix_in,
  input  logic                   pix_valid,
  input  logic                   pix_sof,
  output logic                   pix_ready,
  output logic [N_PIX*PIX_W-1:0] img_source,
  output logic                   valid_top,
  input  logic                   ready_top,
  input  logic [3:0]             number,
  output logic [3:0]             result,
  output logic                   result_err,
  output logic                   result_valid,
  input  logic                   result_ready
);

  localparam int PCNT_W = $clog2(N_PIX);
  localparam int WCNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(N_PIX - 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT_CYC - 1);

  state_e                   state_q, state_d;
  logic [PCNT_W-1:0]        pcnt_q, pcnt_d;
  logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
  logic [N_PIX*PIX_W-1:0]   img_q, img_d;
  logic                     pix_ready_q, pix_ready_d;
  logic                     valid_top_q, valid_top_d;
  logic [3:0]               result_q, result_d;
  logic                     result_err_q, result_err_d;
  logic                     result_valid_q, result_valid_d;
  logic                     pix_xfer;

  assign pix_xfer = pix_valid && pix_ready_q;

  always_comb begin
    state_d      = state_q;
    pcnt_d       = pcnt_q;
    wcnt_d       = wcnt_q;
    img_d        = img_q;
    result_d     = result_q;
    result_err_d = result_err_q;

    unique case (state_q)
      ST_LOAD: begin
        if (pix_xfer) begin
          // A start-of-frame pixel always resynchronises to slot 0.
          if (pix_sof) begin
            img_d[PIX_W-1:0] = pix_in;
            pcnt_d           = PCNT_W'(1);
          end else begin
            img_d[int'(pcnt_q)*PIX_W +: PIX_W] = pix_in;
            if (pcnt_q == PCNT_LAST) begin
              pcnt_d  = '0;
              state_d = ST_FIRE;
            end else begin
              pcnt_d = pcnt_q + 1'b1;
            end
          end
        end
      end

      ST_FIRE: begin
        wcnt_d  = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        // A response in the last allowed cycle still beats the abort.
        if (ready_top) begin
          result_d     = number;
          result_err_d = (number > 4'd9);
          wcnt_d       = '0;
          state_d      = ST_RESULT;
        end else if (wcnt_q == WCNT_LAST) begin
          result_d     = RES_ABORT;
          result_err_d = 1'b1;
          wcnt_d       = '0;
          state_d      = ST_RESULT;
        end
      end

      ST_RESULT: begin
        if (result_ready) begin
          state_d = ST_LOAD;
        end
      end

      default: state_d = ST_LOAD;
    endcase

    // Handshake outputs are registered copies of the next state's decode.
    pix_ready_d    = (state_d == ST_LOAD);
    valid_top_d    = (state_d == ST_FIRE);
    result_valid_d = (state_d == ST_RESULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_LOAD;
      pcnt_q         <= '0;
      wcnt_q         <= '0;
      img_q          <= '0;
      pix_ready_q    <= 1'b1;
      valid_top_q    <= 1'b0;
      result_q       <= '0;
      result_err_q   <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pcnt_q         <= pcnt_d;
      wcnt_q         <= wcnt_d;
      img_q          <= img_d;
      pix_ready_q    <= pix_ready_d;
      valid_top_q    <= valid_top_d;
      result_q       <= result_d;
      result_err_q   <= result_err_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign pix_ready    = pix_ready_q;
  assign img_source   = img_q;
  assign valid_top    = valid_top_q;
  assign result       = result_q;
  assign result_err   = result_err_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_img_feeder_tcb_121.sv
// Self-checking bench for img_feeder_tcb_121: table of frame/NN-response
// vectors plus hand-written reset sequences, results tracked in a scoreboard.
module tb_img_feeder_tcb_121;

  localparam int NP = 121;
  localparam int PW = 8;
  localparam int TO = 1024;

  logic             clk = 1'b0;
  logic             rst;
  logic [PW-1:0]    pix_in;
  logic             pix_valid;
  logic             pix_sof;
  logic             pix_ready;
  logic [NP*PW-1:0] img_source;
  logic             valid_top;
  logic             ready_top;
  logic [3:0]       number;
  logic [3:0]       result;
  logic             result_err;
  logic             result_valid;
  logic             result_ready;

  img_feeder_tcb_121 #(
    .N_PIX(NP),
    .PIX_W(PW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pix_in(pix_in),
    .pix_valid(pix_valid),
    .pix_sof(pix_sof),
    .pix_ready(pix_ready),
    .img_source(img_source),
    .valid_top(valid_top),
    .ready_top(ready_top),
    .number(number),
    .result(result),
    .result_err(result_err),
    .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         pre;
    int         delay;
    bit         use_ready;
    logic [3:0] num;
    logic [7:0] base;
    logic [3:0] exp_res;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [3:0] res;
    logic       err;
  } exp_t;

  vec_t             vecs[6];
  exp_t             sb[$];
  int               checks   = 0;
  int               failures = 0;
  int               vt_seen;
  logic [NP*PW-1:0] exp_img;
  logic [NP*PW-1:0] zero_img;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input logic [NP*PW-1:0] exp);
    int bad_idx;
    bad_idx = -1;
    checks++;
    for (int k = NP - 1; k >= 0; k--) begin
      if (img_source[k*PW +: PW] !== exp[k*PW +: PW]) bad_idx = k;
    end
    if (bad_idx >= 0) begin
      failures++;
      $display("FAIL %s byte=%0d actual=%0h expected=%0h", name, bad_idx,
               img_source[bad_idx*PW +: PW], exp[bad_idx*PW +: PW]);
    end
  endtask

  // Streams n pixels back to back, value base+k, sof on the first if asked.
  task automatic send_pixels(input int n, input bit sof, input logic [7:0] base);
    int not_ready;
    not_ready = 0;
    for (int k = 0; k < n; k++) begin
      pix_in    = base + 8'(k);
      pix_valid = 1'b1;
      pix_sof   = sof && (k == 0);
      if (pix_ready !== 1'b1) not_ready++;
      tick();
      if (k != n - 1 && valid_top === 1'b1) vt_seen++;
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_in    = '0;
    chk("pix_ready_in_load", not_ready, 0);
  endtask

  task automatic run_vector(input int idx);
    vec_t v;
    exp_t e;
    int   bad;
    int   n;
    int   hb;
    v       = vecs[idx];
    vt_seen = 0;
    if (v.pre > 0) send_pixels(v.pre, 1'b1, 8'hA0);
    send_pixels(NP, v.pre > 0, v.base);
    for (int k = 0; k < NP; k++) exp_img[k*PW +: PW] = v.base + 8'(k);

    chk("valid_top_early", vt_seen, 0);
    chk("valid_top_pulse", int'(valid_top), 1);
    chk("pix_ready_fire", int'(pix_ready), 0);
    chk_img("img_at_fire", exp_img);

    ready_top = 1'b0;
    tick();
    chk("valid_top_one_cycle", int'(valid_top), 0);

    bad = 0;
    if (v.use_ready) begin
      for (int d = 0; d < v.delay; d++) begin
        if (result_valid !== 1'b0 || pix_ready !== 1'b0) bad++;
        tick();
      end
      ready_top = 1'b1;
      number    = v.num;
      sb.push_back('{v.exp_res, v.exp_err});
      tick();
      ready_top = 1'b0;
      number    = 4'h0;
      chk("result_latency", int'(result_valid), 1);
    end else begin
      sb.push_back('{v.exp_res, v.exp_err});
      n = 0;
      while (result_valid !== 1'b1 && n < TO + 50) begin
        if (pix_ready !== 1'b0) bad++;
        tick();
        n++;
      end
      chk("timeout_cycles", n, TO);
    end
    chk("wait_quiet", bad, 0);

    e = sb.pop_front();
    chk("result", int'(result), int'(e.res));
    chk("result_err", int'(result_err), int'(e.err));
    chk_img("img_hold", exp_img);

    // Hold with result_ready low; a stray ready_top here must be ignored.
    result_ready = 1'b0;
    ready_top    = 1'b1;
    number       = 4'h2;
    hb           = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (result_valid !== 1'b1 || result !== e.res || result_err !== e.err) hb++;
    end
    chk("result_hold", hb, 0);
    ready_top    = 1'b0;
    number       = 4'h0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    chk("result_release", int'(result_valid), 0);
    chk("pix_ready_after", int'(pix_ready), 1);
  endtask

  initial begin
    int bad;
    zero_img     = '0;
    rst          = 1'b1;
    pix_in       = '0;
    pix_valid    = 1'b0;
    pix_sof      = 1'b0;
    ready_top    = 1'b0;
    number       = 4'h0;
    result_ready = 1'b0;

    vecs[0] = '{0,  40,   1'b1, 4'd7,  8'h00, 4'd7,  1'b0};
    vecs[1] = '{50, 5,    1'b1, 4'd12, 8'h10, 4'd12, 1'b1};
    vecs[2] = '{0,  0,    1'b1, 4'd9,  8'h33, 4'd9,  1'b0};
    vecs[3] = '{0,  1,    1'b1, 4'd10, 8'hF0, 4'd10, 1'b1};
    vecs[4] = '{0,  0,    1'b0, 4'd0,  8'h55, 4'hF,  1'b1};
    vecs[5] = '{0,  1023, 1'b1, 4'd3,  8'h07, 4'd3,  1'b0};

    tick();
    tick();
    chk("rst_pix_ready", int'(pix_ready), 1);
    chk("rst_valid_top", int'(valid_top), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_result_err", int'(result_err), 0);
    chk_img("rst_img", zero_img);
    rst = 1'b0;
    tick();
    chk("pix_ready_after_rst", int'(pix_ready), 1);

    ready_top = 1'b1;
    number    = 4'h5;
    tick();
    tick();
    ready_top = 1'b0;
    number    = 4'h0;
    chk("ready_top_in_load_ignored", int'(result_valid), 0);

    for (int i = 0; i < 6; i++) run_vector(i);

    // Reset mid-frame: the partial frame must not count toward the next one.
    vt_seen = 0;
    send_pixels(60, 1'b1, 8'h40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_img("rst_midframe_img", zero_img);
    send_pixels(61, 1'b0, 8'h01);
    chk("midframe_no_fire", int'(valid_top), 0);
    send_pixels(60, 1'b0, 8'h50);
    chk("midframe_vt_early", vt_seen, 0);
    chk("midframe_refill_fire", int'(valid_top), 1);

    // Reset while waiting on the NN top; its late answer must be dropped.
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_wait_valid_top", int'(valid_top), 0);
    chk("rst_wait_result_valid", int'(result_valid), 0);
    chk("rst_wait_result", int'(result), 0);
    chk("rst_wait_result_err", int'(result_err), 0);
    chk("rst_wait_pix_ready", int'(pix_ready), 1);
    chk_img("rst_wait_img", zero_img);
    ready_top = 1'b1;
    number    = 4'h7;
    bad       = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (result_valid !== 1'b0 || valid_top !== 1'b0 || pix_ready !== 1'b1) bad++;
    end
    ready_top = 1'b0;
    number    = 4'h0;
    chk("late_ready_ignored", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
